// File: rtl/line_sync_gen_if.sv
// Line/frame sync bundle between the generator and its downstream consumer.
// The generator side takes the enable and frame-request controls and drives
// the pixel/line timing outputs.
interface line_sync_gen_if;
    logic       gen_enb;
    logic       start;
    logic       pix_valid;
    logic [7:0] pix_x;
    logic [4:0] line_idx;
    logic       newLine;
    logic       frameStart;
    logic       endFrame;
    logic       busy;

    modport master (
        input  gen_enb,
        input  start,
        output pix_valid,
        output pix_x,
        output line_idx,
        output newLine,
        output frameStart,
        output endFrame,
        output busy
    );

    modport slave (
        output gen_enb,
        output start,
        input  pix_valid,
        input  pix_x,
        input  line_idx,
        input  newLine,
        input  frameStart,
        input  endFrame,
        input  busy
    );
endinterface

// File: rtl/line_sync_gen.sv
// Line sync generator: walks H_ACTIVE pixel clocks and H_BLANK blanking
// clocks per line for V_LINES lines, then pulses endFrame for one clock.
// Every output is decoded from registered state and counters, so no input
// reaches an output combinationally.
// Build option: define LINE_SYNC_GEN_AUTORESTART_EN to chain frames
// back-to-back from DONE while gen_enb stays high; otherwise every frame
// needs its own start.
module line_sync_gen #(
    parameter int unsigned H_ACTIVE = 32,
    parameter int unsigned H_BLANK  = 4,
    parameter int unsigned V_LINES  = 24
) (
    input logic             clk,
    input logic             rst_n,
    line_sync_gen_if.master bus
);

    localparam logic [7:0] PixLast   = 8'(H_ACTIVE - 1);
    localparam logic [7:0] BlankLast = 8'(H_BLANK - 1);
    localparam logic [4:0] LineLast  = 5'(V_LINES - 1);

    typedef enum logic [1:0] {StIdle, StActive, StBlank, StDone} state_e;

    state_e     state_q, state_d;
    logic [7:0] pix_x_q, pix_x_d;
    logic [4:0] line_q, line_d;
    logic [7:0] blank_q, blank_d;

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            pix_x_q <= '0;
            line_q  <= '0;
            blank_q <= '0;
        end else begin
            state_q <= state_d;
            pix_x_q <= pix_x_d;
            line_q  <= line_d;
            blank_q <= blank_d;
        end
    end

    // Next-state and counter update; counters hold unless explicitly advanced.
    always_comb begin
        state_d = state_q;
        pix_x_d = pix_x_q;
        line_d  = line_q;
        blank_d = blank_q;
        if (!bus.gen_enb) begin
            // Abort: drop back to idle with clean counters, no end-of-line/frame pulses.
            state_d = StIdle;
            pix_x_d = '0;
            line_d  = '0;
            blank_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        state_d = StActive;
                        pix_x_d = '0;
                        line_d  = '0;
                        blank_d = '0;
                    end
                end
                StActive: begin
                    if (pix_x_q == PixLast) begin
                        state_d = StBlank;
                        blank_d = '0;
                    end else begin
                        pix_x_d = pix_x_q + 8'd1;
                    end
                end
                StBlank: begin
                    if (blank_q == BlankLast) begin
                        blank_d = '0;
                        if (line_q == LineLast) begin
                            state_d = StDone;
                        end else begin
                            state_d = StActive;
                            line_d  = line_q + 5'd1;
                            pix_x_d = '0;
                        end
                    end else begin
                        blank_d = blank_q + 8'd1;
                    end
                end
                StDone: begin
`ifdef LINE_SYNC_GEN_AUTORESTART_EN
                    // gen_enb is known high here; chain straight into the next frame.
                    state_d = StActive;
                    pix_x_d = '0;
                    line_d  = '0;
`else
                    state_d = StIdle;
`endif
                end
            endcase
        end
    end

    // Output decode from registered state only.
    always_comb begin
        bus.pix_valid  = (state_q == StActive);
        bus.pix_x      = pix_x_q;
        bus.line_idx   = line_q;
        bus.newLine    = (state_q == StBlank) && (blank_q == BlankLast);
        bus.frameStart = (state_q == StActive) && (pix_x_q == '0) && (line_q == '0);
        bus.endFrame   = (state_q == StDone);
        bus.busy       = (state_q != StIdle);
    end

endmodule

// File: tb/tb_line_sync_gen.sv
// Directed bench for line_sync_gen: a small instance (4/2/3) and a default
// instance (32/4/24). Expected per-clock outputs are queued when stimulus is
// driven and popped after each rising edge; an empty queue means idle with
// the last held counter values.
module tb_line_sync_gen;

    typedef struct packed {
        logic       pv;
        logic [7:0] px;
        logic [4:0] li;
        logic       nl;
        logic       fs;
        logic       ef;
        logic       busy;
    } obs_t;

    logic clk;
    logic rst_n;

    line_sync_gen_if if_s ();
    line_sync_gen_if if_d ();

    line_sync_gen #(.H_ACTIVE(4), .H_BLANK(2), .V_LINES(3)) dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_s)
    );

    line_sync_gen dut_d (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    obs_t  q_s[$];
    obs_t  q_d[$];
    int    hx[2];
    int    hl[2];
    int    vectors     = 0;
    int    miscompares = 0;
    int    nl_d        = 0;
    int    nl_at_ef    = -1;
    string tag         = "reset";

    function automatic obs_t obs_s();
        return {if_s.pix_valid, if_s.pix_x, if_s.line_idx, if_s.newLine,
                if_s.frameStart, if_s.endFrame, if_s.busy};
    endfunction

    function automatic obs_t obs_d();
        return {if_d.pix_valid, if_d.pix_x, if_d.line_idx, if_d.newLine,
                if_d.frameStart, if_d.endFrame, if_d.busy};
    endfunction

    function automatic void push(input int which, input obs_t e);
        if (which == 0) q_s.push_back(e);
        else            q_d.push_back(e);
    endfunction

    // Expected outputs of one frame starting on the next edge, truncated to limit clocks.
    function automatic void push_frame(input int which, input int ha, input int hb,
                                       input int vl, input int limit);
        int n = 0;
        for (int l = 0; l < vl; l++) begin
            for (int x = 0; x < ha; x++) begin
                if (n < limit) push(which, {1'b1, 8'(x), 5'(l), 1'b0,
                                            (x == 0 && l == 0), 1'b0, 1'b1});
                n++;
            end
            for (int b = 0; b < hb; b++) begin
                if (n < limit) push(which, {1'b0, 8'(ha - 1), 5'(l), (b == hb - 1),
                                            1'b0, 1'b0, 1'b1});
                n++;
            end
        end
        if (n < limit) push(which, {1'b0, 8'(ha - 1), 5'(vl - 1), 1'b0, 1'b0, 1'b1, 1'b1});
        n++;
        if (limit >= n) begin
            hx[which] = ha - 1;
            hl[which] = vl - 1;
        end else begin
            hx[which] = 0;
            hl[which] = 0;
        end
    endfunction

    task automatic check(input int which, input obs_t o);
        obs_t e;
        if (which == 0 && q_s.size() > 0)      e = q_s.pop_front();
        else if (which == 1 && q_d.size() > 0) e = q_d.pop_front();
        else e = {1'b0, 8'(hx[which]), 5'(hl[which]), 1'b0, 1'b0, 1'b0, 1'b0};
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s/%s at %0t: observed pv=%b px=%0d li=%0d nl=%b fs=%b ef=%b busy=%b, expected pv=%b px=%0d li=%0d nl=%b fs=%b ef=%b busy=%b",
                   tag, (which == 0) ? "small" : "dflt", $time,
                   o.pv, o.px, o.li, o.nl, o.fs, o.ef, o.busy,
                   e.pv, e.px, e.li, e.nl, e.fs, e.ef, e.busy);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (if_d.endFrame === 1'b1) nl_at_ef = nl_d;
            if (if_d.newLine === 1'b1)  nl_d++;
            check(0, obs_s());
            check(1, obs_d());
        end
    endtask

    initial begin
        hx = '{0, 0};
        hl = '{0, 0};
        if_s.gen_enb = 1'b0;
        if_s.start   = 1'b0;
        if_d.gen_enb = 1'b0;
        if_d.start   = 1'b0;
        rst_n        = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check(0, obs_s());
        check(1, obs_d());
        @(negedge clk);
        rst_n = 1'b1;
        tick(2);

`ifdef LINE_SYNC_GEN_AUTORESTART_EN
        tag = "autorestart";
        if_s.gen_enb = 1'b1;
        if_s.start   = 1'b1;
        for (int f = 0; f < 3; f++) push_frame(0, 4, 2, 3, 1000);
        tick(1);
        if_s.start = 1'b0;
        tick(56);
        if_s.gen_enb = 1'b0;
        hx[0] = 0;
        hl[0] = 0;
        tick(3);
`else
        // Basic frame, then busy drops and counters hold after DONE.
        tag = "frame";
        if_s.gen_enb = 1'b1;
        if_s.start   = 1'b1;
        push_frame(0, 4, 2, 3, 1000);
        tick(1);
        if_s.start = 1'b0;
        tick(18);
        tag = "after_done";
        tick(2);

        // Start during ACTIVE of line 0 is ignored.
        tag = "start_busy";
        if_s.start = 1'b1;
        push_frame(0, 4, 2, 3, 1000);
        tick(1);
        if_s.start = 1'b0;
        tick(2);
        if_s.start = 1'b1;
        tick(1);
        if_s.start = 1'b0;
        tick(16);
        tick(1);

        // gen_enb dropped in the first BLANK clock of line 1.
        tag = "abort";
        if_s.start = 1'b1;
        push_frame(0, 4, 2, 3, 11);
        tick(1);
        if_s.start = 1'b0;
        tick(10);
        if_s.gen_enb = 1'b0;
        tick(4);
        tag = "start_disabled";
        if_s.start = 1'b1;
        tick(1);
        if_s.start   = 1'b0;
        if_s.gen_enb = 1'b1;
        tick(1);

        // Asynchronous reset at line 1, pixel 2.
        tag = "reset_mid";
        if_s.start = 1'b1;
        push_frame(0, 4, 2, 3, 9);
        tick(1);
        if_s.start = 1'b0;
        tick(8);
        #2 rst_n = 1'b0;
        hx[0] = 0;
        hl[0] = 0;
        #1;
        check(0, obs_s());
        check(1, obs_d());
        @(negedge clk);
        rst_n = 1'b1;
        tag = "post_reset";
        if_s.start = 1'b1;
        push_frame(0, 4, 2, 3, 1000);
        tick(1);
        if_s.start = 1'b0;
        tick(20);

        // Default-size frame: 24 lines, newLine count aligned with endFrame.
        tag = "dflt_frame";
        nl_d = 0;
        if_d.gen_enb = 1'b1;
        if_d.start   = 1'b1;
        push_frame(1, 32, 4, 24, 100000);
        tick(1);
        if_d.start = 1'b0;
        tick(24 * 36);
        tick(2);
        vectors++;
        assert (nl_at_ef === 24) else begin
            miscompares++;
            $error("FAIL dflt_newline_count: observed %0d newLine before endFrame, expected 24",
                   nl_at_ef);
        end
        vectors++;
        assert (nl_d === 24) else begin
            miscompares++;
            $error("FAIL dflt_newline_total: observed %0d, expected 24", nl_d);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
